// File: rtl/wb_stage_q.sv
// wb_stage_q: in-order writeback queue between the MEM stage and the
// regfile / HI-LO registers.
//   Holds up to DEPTH instructions so MEM can issue further data requests
//   before earlier responses return. data_data_ok always completes the head
//   entry. Load data is formatted for lb/lbu/lh/lhu/lw/lwl/lwr, and at most one
//   instruction retires per cycle.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   mem_*              instruction fields presented by MEM (push when
//                      mem_valid && wb_allowin)
//   data_data_ok/rdata in-order data response for the head entry
//   wb_allowin         queue can accept an instruction this cycle
//   wb_valid, wb_pc    queue non-empty, head PC (0 when empty)
//   rf_wen/waddr/wdata regfile write port (wen gated by retire)
//   hi, lo             architectural HI/LO registers
//   pending            number of queued entries
//   resp_err           sticky: response arrived with no head awaiting data
module wb_stage_q #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             mem_valid,
   input  logic [31:0]      mem_pc,
   input  logic [3:0]       mem_rf_wen,
   input  logic [4:0]       mem_rf_waddr,
   input  logic [2:0]       mem_load_op,
   input  logic [1:0]       mem_byte_off,
   input  logic [31:0]      mem_rt_data,
   input  logic [31:0]      mem_result,
   input  logic             mem_data_req,
   input  logic             mem_hi_we,
   input  logic             mem_lo_we,
   input  logic [31:0]      mem_hi_wdata,
   input  logic [31:0]      mem_lo_wdata,
   input  logic             data_data_ok,
   input  logic [31:0]      data_rdata,
   output logic             wb_allowin,
   output logic             wb_valid,
   output logic [31:0]      wb_pc,
   output logic [3:0]       rf_wen,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic [31:0]      hi,
   output logic [31:0]      lo,
   output logic [PTR_W:0]   pending,
   output logic             resp_err
);

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LW   = 3'd1,
      OP_LB   = 3'd2,
      OP_LBU  = 3'd3,
      OP_LH   = 3'd4,
      OP_LHU  = 3'd5,
      OP_LWL  = 3'd6,
      OP_LWR  = 3'd7
   } load_op_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  rf_wen;
      logic [4:0]  rf_waddr;
      load_op_e    load_op;
      logic [1:0]  byte_off;
      logic [31:0] rt_data;
      logic [31:0] result;
      logic        need_data;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi_wdata;
      logic [31:0] lo_wdata;
   } entry_t;

   localparam logic [PTR_W:0] LP_DEPTH = (PTR_W + 1)'(DEPTH);

   entry_t           r_q [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic             r_resp_err;

   entry_t           w_head;
   entry_t           w_new;
   logic             w_push;
   logic             w_retire;
   logic             w_stray;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_fmt;

   assign w_head     = r_q[r_head];
   assign wb_valid   = (r_count != '0);
   assign w_retire   = wb_valid && (!w_head.need_data || data_data_ok);
   // A full queue still accepts when the head leaves in the same cycle.
   assign wb_allowin = (r_count < LP_DEPTH) || w_retire;
   assign w_push     = mem_valid && wb_allowin;
   assign w_stray    = data_data_ok && (!wb_valid || !w_head.need_data);

   assign w_new = '{
      pc:        mem_pc,
      rf_wen:    mem_rf_wen,
      rf_waddr:  mem_rf_waddr,
      load_op:   load_op_e'(mem_load_op),
      byte_off:  mem_byte_off,
      rt_data:   mem_rt_data,
      result:    mem_result,
      need_data: mem_data_req,
      hi_we:     mem_hi_we,
      lo_we:     mem_lo_we,
      hi_wdata:  mem_hi_wdata,
      lo_wdata:  mem_lo_wdata
   };

   // Entry contents need no reset: every consumer is gated by wb_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q[r_tail] <= w_new;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_resp_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_retire) begin
            r_head <= r_head + 1'b1;
            if (w_head.hi_we) begin
               r_hi <= w_head.hi_wdata;
            end
            if (w_head.lo_we) begin
               r_lo <= w_head.lo_wdata;
            end
         end
         if (w_push && !w_retire) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_retire) begin
            r_count <= r_count - 1'b1;
         end
         if (w_stray) begin
            r_resp_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_byte = data_rdata[7:0];
      case (w_head.byte_off)
         2'd0: w_byte = data_rdata[7:0];
         2'd1: w_byte = data_rdata[15:8];
         2'd2: w_byte = data_rdata[23:16];
         2'd3: w_byte = data_rdata[31:24];
         default: w_byte = data_rdata[7:0];
      endcase
      w_half = w_head.byte_off[1] ? data_rdata[31:16] : data_rdata[15:0];

      w_fmt = w_head.result;
      case (w_head.load_op)
         OP_NONE: w_fmt = w_head.result;
         OP_LW:   w_fmt = data_rdata;
         OP_LB:   w_fmt = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_fmt = {24'd0, w_byte};
         OP_LH:   w_fmt = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_fmt = {16'd0, w_half};
         OP_LWL: begin
            case (w_head.byte_off)
               2'd0: w_fmt = {data_rdata[7:0],  w_head.rt_data[23:0]};
               2'd1: w_fmt = {data_rdata[15:0], w_head.rt_data[15:0]};
               2'd2: w_fmt = {data_rdata[23:0], w_head.rt_data[7:0]};
               default: w_fmt = data_rdata;
            endcase
         end
         OP_LWR: begin
            case (w_head.byte_off)
               2'd0: w_fmt = data_rdata;
               2'd1: w_fmt = {w_head.rt_data[31:24], data_rdata[31:8]};
               2'd2: w_fmt = {w_head.rt_data[31:16], data_rdata[31:16]};
               default: w_fmt = {w_head.rt_data[31:8], data_rdata[31:24]};
            endcase
         end
         default: w_fmt = w_head.result;
      endcase
   end

   assign rf_wen   = w_retire ? w_head.rf_wen : '0;
   assign rf_waddr = wb_valid ? w_head.rf_waddr : '0;
   assign wb_pc    = wb_valid ? w_head.pc : '0;
   assign rf_wdata = wb_valid ? w_fmt : '0;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign pending  = r_count;
   assign resp_err = r_resp_err;

endmodule

// File: tb/tb_wb_stage_q.sv
// tb_wb_stage_q: directed scenarios plus randomized traffic for wb_stage_q,
// checked against a queue-based reference model of the writeback stage.
module tb_wb_stage_q;

   localparam int DEPTH = 2;
   localparam int PTR_W = 1;

   logic             clk = 1'b0;
   logic             resetn;
   logic             mem_valid;
   logic [31:0]      mem_pc;
   logic [3:0]       mem_rf_wen;
   logic [4:0]       mem_rf_waddr;
   logic [2:0]       mem_load_op;
   logic [1:0]       mem_byte_off;
   logic [31:0]      mem_rt_data;
   logic [31:0]      mem_result;
   logic             mem_data_req;
   logic             mem_hi_we;
   logic             mem_lo_we;
   logic [31:0]      mem_hi_wdata;
   logic [31:0]      mem_lo_wdata;
   logic             data_data_ok;
   logic [31:0]      data_rdata;
   logic             wb_allowin;
   logic             wb_valid;
   logic [31:0]      wb_pc;
   logic [3:0]       rf_wen;
   logic [4:0]       rf_waddr;
   logic [31:0]      rf_wdata;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [PTR_W:0]   pending;
   logic             resp_err;

   int checks = 0;
   int errors = 0;

   wb_stage_q #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_rf_wen(mem_rf_wen),
      .mem_rf_waddr(mem_rf_waddr), .mem_load_op(mem_load_op),
      .mem_byte_off(mem_byte_off), .mem_rt_data(mem_rt_data),
      .mem_result(mem_result), .mem_data_req(mem_data_req),
      .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we),
      .mem_hi_wdata(mem_hi_wdata), .mem_lo_wdata(mem_lo_wdata),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .wb_allowin(wb_allowin), .wb_valid(wb_valid), .wb_pc(wb_pc),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi(hi), .lo(lo), .pending(pending), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue of instructions plus HI/LO/error state.
   typedef struct {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  waddr;
      int          op;
      int          off;
      logic [31:0] rt;
      logic [31:0] res;
      bit          need;
      bit          hwe;
      bit          lwe;
      logic [31:0] hd;
      logic [31:0] ld;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;
   bit          m_err = 1'b0;

   function automatic logic [31:0] fmt(int op, int o, logic [31:0] rt,
                                       logic [31:0] d, logic [31:0] res);
      logic [31:0] b, h, m;
      b = (d >> (8 * o)) & 32'hFF;
      h = (d >> (16 * (o / 2))) & 32'hFFFF;
      case (op)
         0: return res;
         1: return d;
         2: return (b >= 32'd128) ? b - 32'd256 : b;
         3: return b;
         4: return (h >= 32'd32768) ? h - 32'd65536 : h;
         5: return h;
         6: begin
            m = (32'd1 << (8 * (3 - o))) - 32'd1;
            return (d << (8 * (3 - o))) | (rt & m);
         end
         7: begin
            m = 32'hFFFF_FFFF >> (8 * o);
            return (d >> (8 * o)) | (rt & ~m);
         end
         default: return 32'd0;
      endcase
   endfunction

   // Advances one clock edge, updating the model from the inputs in force.
   task automatic advance();
      bit    ret, psh, stray;
      ment_t e;
      ret   = (mq.size() > 0) && (!mq[0].need || data_data_ok);
      psh   = mem_valid && ((mq.size() < DEPTH) || ret);
      stray = data_data_ok && ((mq.size() == 0) || !mq[0].need);
      e = '{pc: mem_pc, wen: mem_rf_wen, waddr: mem_rf_waddr,
            op: int'(mem_load_op), off: int'(mem_byte_off), rt: mem_rt_data,
            res: mem_result, need: mem_data_req, hwe: mem_hi_we,
            lwe: mem_lo_we, hd: mem_hi_wdata, ld: mem_lo_wdata};
      @(posedge clk);
      if (!resetn) begin
         mq.delete();
         m_hi  = '0;
         m_lo  = '0;
         m_err = 1'b0;
      end else begin
         if (ret) begin
            if (mq[0].hwe) m_hi = mq[0].hd;
            if (mq[0].lwe) m_lo = mq[0].ld;
            void'(mq.pop_front());
         end
         if (psh) mq.push_back(e);
         if (stray) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic clr_inputs();
      mem_valid = 0; mem_pc = '0; mem_rf_wen = '0; mem_rf_waddr = '0;
      mem_load_op = '0; mem_byte_off = '0; mem_rt_data = '0; mem_result = '0;
      mem_data_req = 0; mem_hi_we = 0; mem_lo_we = 0; mem_hi_wdata = '0;
      mem_lo_wdata = '0; data_data_ok = 0; data_rdata = '0;
   endtask

   task automatic push_in(input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wa, input logic [2:0] op,
                          input logic [1:0] off, input logic [31:0] rt,
                          input logic [31:0] res, input bit req,
                          input bit hwe, input bit lwe,
                          input logic [31:0] hd, input logic [31:0] ld);
      mem_valid = 1; mem_pc = pc; mem_rf_wen = wen; mem_rf_waddr = wa;
      mem_load_op = op; mem_byte_off = off; mem_rt_data = rt;
      mem_result = res; mem_data_req = req; mem_hi_we = hwe; mem_lo_we = lwe;
      mem_hi_wdata = hd; mem_lo_wdata = ld;
   endtask

   task automatic test_reset();
      resetn = 0; clr_inputs(); #1;
      advance(); advance();
      resetn = 1; #1;
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
      checks++; if (wb_valid !== 1'b0 || wb_allowin !== 1'b1) begin errors++; $display("FAIL reset_flags valid=%b allowin=%b want 0/1", wb_valid, wb_allowin); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo); end
      checks++; if (resp_err !== 1'b0 || rf_wen !== 4'd0 || wb_pc !== 32'd0) begin errors++; $display("FAIL reset_outs err=%b wen=%h pc=%h want 0", resp_err, rf_wen, wb_pc); end
   endtask

   task automatic test_alu();
      push_in(32'h400, 4'hF, 5'd5, 3'd0, 2'd0, 32'd0, 32'h1234_5678, 0, 0, 0, 0, 0);
      #1;
      checks++; if (wb_valid !== 1'b0 || rf_wen !== 4'd0) begin errors++; $display("FAIL alu_nobypass valid=%b wen=%h want 0/0", wb_valid, rf_wen); end
      advance(); clr_inputs(); #1;
      checks++; if (rf_wen !== 4'hF || rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_retire wen=%h data=%h want F/12345678", rf_wen, rf_wdata); end
      checks++; if (rf_waddr !== 5'd5 || wb_pc !== 32'h400) begin errors++; $display("FAIL alu_head waddr=%0d pc=%h want 5/400", rf_waddr, wb_pc); end
      advance(); #1;
      checks++; if (pending !== 2'd0) begin errors++; $display("FAIL alu_drain pending=%0d want 0", pending); end
   endtask

   task automatic test_fill_stall();
      push_in(32'h500, 4'hF, 5'd3, 3'd2, 2'd1, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      push_in(32'h504, 4'hF, 5'd4, 3'd5, 2'd2, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      clr_inputs(); #1;
      checks++; if (wb_allowin !== 1'b0 || pending !== 2'd2 || rf_wen !== 4'd0) begin errors++; $display("FAIL full_stall allowin=%b pending=%0d wen=%h want 0/2/0", wb_allowin, pending, rf_wen); end
      advance();
      data_data_ok = 1; data_rdata = 32'h80FF_7F00; #1;
      checks++; if (rf_wen !== 4'hF || rf_wdata !== 32'h0000_007F || rf_waddr !== 5'd3) begin errors++; $display("FAIL lb_o1 wen=%h data=%h waddr=%0d want F/0000007F/3", rf_wen, rf_wdata, rf_waddr); end
      advance();
      data_rdata = 32'hBEEF_0000; #1;
      checks++; if (rf_wen !== 4'hF || rf_wdata !== 32'h0000_BEEF || rf_waddr !== 5'd4) begin errors++; $display("FAIL lhu_o2 wen=%h data=%h waddr=%0d want F/0000BEEF/4", rf_wen, rf_wdata, rf_waddr); end
      advance(); clr_inputs(); #1;
      checks++; if (pending !== 2'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL fill_drain pending=%0d err=%b want 0/0", pending, resp_err); end
   endtask

   task automatic test_back_to_back();
      push_in(32'h600, 4'hF, 5'd1, 3'd1, 2'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      push_in(32'h604, 4'hF, 5'd2, 3'd1, 2'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      push_in(32'h608, 4'hF, 5'd7, 3'd0, 2'd0, 32'd0, 32'h0000_C0C0, 0, 0, 0, 0, 0);
      data_data_ok = 1; data_rdata = 32'h5566_7788; #1;
      checks++; if (wb_allowin !== 1'b1 || rf_wdata !== 32'h5566_7788) begin errors++; $display("FAIL full_push_retire allowin=%b data=%h want 1/55667788", wb_allowin, rf_wdata); end
      advance();
      clr_inputs(); #1;
      checks++; if (pending !== 2'd2 || wb_pc !== 32'h604) begin errors++; $display("FAIL full_push_count pending=%0d pc=%h want 2/604", pending, wb_pc); end
      data_data_ok = 1; data_rdata = 32'h99; #1;
      advance();
      clr_inputs(); #1;
      checks++; if (rf_wdata !== 32'h0000_C0C0 || rf_wen !== 4'hF || rf_waddr !== 5'd7) begin errors++; $display("FAIL third_entry data=%h wen=%h waddr=%0d want C0C0/F/7", rf_wdata, rf_wen, rf_waddr); end
      advance(); #1;
   endtask

   task automatic test_lwl_lwr();
      push_in(32'h700, 4'hF, 5'd8, 3'd6, 2'd1, 32'hAABB_CCDD, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      push_in(32'h704, 4'hF, 5'd8, 3'd7, 2'd2, 32'hAABB_CCDD, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      clr_inputs(); data_data_ok = 1; data_rdata = 32'h1122_3344; #1;
      checks++; if (rf_wdata !== 32'h3344_CCDD) begin errors++; $display("FAIL lwl_o1 got %h want 3344CCDD", rf_wdata); end
      advance();
      checks++; if (rf_wdata !== 32'hAABB_1122) begin errors++; $display("FAIL lwr_o2 got %h want AABB1122", rf_wdata); end
      advance(); clr_inputs(); #1;
   endtask

   task automatic test_hilo();
      push_in(32'h800, 4'hF, 5'd9, 3'd1, 2'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance();
      push_in(32'h804, 4'h0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0, 0, 1, 0, 32'hDEAD_0001, 0);
      #1; advance();
      clr_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (hi !== 32'd0) begin errors++; $display("FAIL hi_stalled cycle %0d got %h want 0", i, hi); end
         advance();
      end
      data_data_ok = 1; data_rdata = 32'h1; #1;
      advance();
      clr_inputs(); #1;
      checks++; if (hi !== 32'd0 || rf_wen !== 4'd0 || wb_valid !== 1'b1) begin errors++; $display("FAIL mthi_at_head hi=%h wen=%h valid=%b want 0/0/1", hi, rf_wen, wb_valid); end
      advance(); #1;
      checks++; if (hi !== 32'hDEAD_0001 || pending !== 2'd0) begin errors++; $display("FAIL mthi_done hi=%h pending=%0d want DEAD0001/0", hi, pending); end
      push_in(32'h808, 4'h0, 5'd0, 3'd0, 2'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0BAD_0002);
      #1; advance(); clr_inputs(); #1; advance(); #1;
      checks++; if (lo !== 32'h0BAD_0002 || hi !== 32'hDEAD_0001) begin errors++; $display("FAIL mtlo_done lo=%h hi=%h want 0BAD0002/DEAD0001", lo, hi); end
   endtask

   task automatic test_resp_err_reset();
      clr_inputs(); data_data_ok = 1; #1;
      checks++; if (rf_wen !== 4'd0) begin errors++; $display("FAIL stray_wen got %h want 0", rf_wen); end
      advance(); data_data_ok = 0; #1;
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL stray_err got %b want 1", resp_err); end
      push_in(32'h900, 4'hF, 5'd6, 3'd1, 2'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0);
      #1; advance(); clr_inputs(); #1;
      checks++; if (pending !== 2'd1) begin errors++; $display("FAIL stall_pending got %0d want 1", pending); end
      resetn = 0; #1; advance(); resetn = 1; #1;
      checks++; if (pending !== 2'd0 || resp_err !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL midreset pending=%0d err=%b valid=%b want 0/0/0", pending, resp_err, wb_valid); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_hilo hi=%h lo=%h want 0/0", hi, lo); end
      data_data_ok = 1; #1; advance(); data_data_ok = 0; #1;
      checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL late_resp_err got %b want 1", resp_err); end
   endtask

   task automatic test_random();
      bit          e_val, e_ret, e_allow;
      logic [3:0]  e_wen;
      logic [4:0]  e_wa;
      logic [31:0] e_pc, e_wd;
      resetn = 0; clr_inputs(); #1; advance(); resetn = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         resetn       = ($urandom_range(0, 199) != 0);
         mem_valid    = $urandom_range(0, 1);
         mem_pc       = $urandom;
         mem_rf_wen   = 4'($urandom);
         mem_rf_waddr = 5'($urandom);
         mem_load_op  = 3'($urandom);
         mem_byte_off = 2'($urandom);
         mem_rt_data  = $urandom;
         mem_result   = $urandom;
         mem_data_req = (mem_load_op != 3'd0) || ($urandom_range(0, 3) == 0);
         mem_hi_we    = ($urandom_range(0, 7) == 0);
         mem_lo_we    = ($urandom_range(0, 7) == 0);
         mem_hi_wdata = $urandom;
         mem_lo_wdata = $urandom;
         if (mq.size() > 0 && mq[0].need) data_data_ok = $urandom_range(0, 1);
         else data_data_ok = ($urandom_range(0, 15) == 0);
         data_rdata = $urandom;
         #1;
         e_val   = (mq.size() > 0);
         e_ret   = e_val && (!mq[0].need || data_data_ok);
         e_allow = (mq.size() < DEPTH) || e_ret;
         e_wen   = e_ret ? mq[0].wen : 4'd0;
         e_wa    = e_val ? mq[0].waddr : 5'd0;
         e_pc    = e_val ? mq[0].pc : 32'd0;
         e_wd    = e_val ? fmt(mq[0].op, mq[0].off, mq[0].rt, data_rdata, mq[0].res) : 32'd0;
         checks++; if (wb_valid !== e_val || wb_allowin !== e_allow) begin errors++; $display("FAIL rnd_flags cyc %0d valid=%b allowin=%b want %b/%b", cyc, wb_valid, wb_allowin, e_val, e_allow); end
         checks++; if (int'(pending) !== mq.size()) begin errors++; $display("FAIL rnd_pending cyc %0d got %0d want %0d", cyc, pending, mq.size()); end
         checks++; if (rf_wen !== e_wen || rf_waddr !== e_wa || wb_pc !== e_pc) begin errors++; $display("FAIL rnd_head cyc %0d wen=%h waddr=%0d pc=%h want %h/%0d/%h", cyc, rf_wen, rf_waddr, wb_pc, e_wen, e_wa, e_pc); end
         checks++; if (rf_wdata !== e_wd) begin errors++; $display("FAIL rnd_wdata cyc %0d got %h want %h", cyc, rf_wdata, e_wd); end
         checks++; if (hi !== m_hi || lo !== m_lo || resp_err !== m_err) begin errors++; $display("FAIL rnd_state cyc %0d hi=%h lo=%h err=%b want %h/%h/%b", cyc, hi, lo, resp_err, m_hi, m_lo, m_err); end
         advance();
      end
      resetn = 1; clr_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 0;
      clr_inputs();
      test_reset();
      test_alu();
      test_fill_stall();
      test_back_to_back();
      test_lwl_lwr();
      test_hilo();
      test_resp_err_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
